// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/empty controller of the async FIFO (rclk domain); optional macro RD_LEVEL_EN adds fill level and almost-empty.
// Latency: rempty/rptr update on the same rclk edge as the pop; backpressure: pops are ignored while empty and flagged as underflow.
module fifo_rd_ctrl #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                runderflow_clr,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                runderflow,
    output logic [ADDRSIZE:0]   rd_level,
    output logic                ralmost_empty
);

    logic [ADDRSIZE:0] r_rbin;
    logic [ADDRSIZE:0] r_rptr;
    logic              r_rempty;
    logic              r_runderflow;

    logic              w_rd_vld;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;

    assign w_rd_vld    = rinc & ~r_rempty;
    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rd_vld};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // Compare against the new Gray pointer so the flag never lags the emptying pop.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_rempty <= 1'b1;
        end else begin
            r_rbin   <= w_rbinnext;
            r_rptr   <= w_rgraynext;
            r_rempty <= (w_rgraynext == rq2_wptr);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_runderflow <= 1'b0;
        end else if (rinc & r_rempty) begin
            r_runderflow <= 1'b1;
        end else if (runderflow_clr) begin
            r_runderflow <= 1'b0;
        end
    end

    assign raddr      = r_rbin[ADDRSIZE-1:0];
    assign rptr       = r_rptr;
    assign rempty     = r_rempty;
    assign runderflow = r_runderflow;

`ifdef RD_LEVEL_EN
    localparam logic [ADDRSIZE:0] AE_LVL = AE_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] w_wbin;
    logic [ADDRSIZE:0] w_level;
    logic [ADDRSIZE:0] r_rd_level;
    logic              r_ralmost_empty;

    // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_wbin[i] = ^(rq2_wptr >> i);
        end
    end

    assign w_level = w_wbin - w_rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rd_level      <= '0;
            r_ralmost_empty <= 1'b1;
        end else begin
            r_rd_level      <= w_level;
            r_ralmost_empty <= (w_level <= AE_LVL);
        end
    end

    assign rd_level      = r_rd_level;
    assign ralmost_empty = r_ralmost_empty;
`else
    // With the level held at zero, zero <= threshold always holds.
    localparam bit AE_TIE = (AE_THRESH >= 0);

    assign rd_level      = '0;
    assign ralmost_empty = AE_TIE;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: vector table, hand sequences for reset/wrap/level, and randomized traffic against a count-based model.
module tb_fifo_rd_ctrl;
    localparam int AW = 4;
    localparam int PW = 32;
`ifdef RD_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rinc;
    logic          runderflow_clr;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          runderflow;
    logic [AW:0]   rd_level;
    logic          ralmost_empty;

    fifo_rd_ctrl #(.ADDRSIZE(AW), .AE_THRESH(1)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .runderflow_clr(runderflow_clr),
        .rq2_wptr(rq2_wptr), .raddr(raddr), .rptr(rptr), .rempty(rempty),
        .runderflow(runderflow), .rd_level(rd_level), .ralmost_empty(ralmost_empty)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: read count, flags, level
    int m_r, m_empty, m_uf, m_lvl, m_ae;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) % PW;
    endfunction

    function automatic int ungray(input int g);
        for (int b = 0; b < PW; b++)
            if (gray(b) == g) return b;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r = 0; m_empty = 1; m_uf = 0; m_lvl = 0; m_ae = 1;
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, "_raddr"}, int'(raddr), m_r % 16);
        chk({tag, "_rptr"}, int'(rptr), gray(m_r));
        chk({tag, "_rempty"}, int'(rempty), m_empty);
        chk({tag, "_runderflow"}, int'(runderflow), m_uf);
        chk({tag, "_rd_level"}, int'(rd_level), LVL_EN ? m_lvl : 0);
        chk({tag, "_ralmost_empty"}, int'(ralmost_empty), LVL_EN ? m_ae : 1);
    endtask

    // One rclk edge: model samples the same inputs the DUT sees, then outputs are read 1ns later.
    task automatic tick();
        int w, nr, was_empty;
        @(posedge rclk);
        w = ungray(int'(rq2_wptr));
        was_empty = m_empty;
        nr = (rinc && !was_empty) ? (m_r + 1) % PW : m_r;
        m_empty = (w == nr) ? 1 : 0;
        if (rinc && was_empty) m_uf = 1;
        else if (runderflow_clr) m_uf = 0;
        m_lvl = (w - nr + PW) % PW;
        m_ae = (m_lvl <= 1) ? 1 : 0;
        m_r = nr;
        #1;
    endtask

    task automatic do_reset();
        rinc = 0; runderflow_clr = 0; rq2_wptr = '0;
        rrst_n = 0;
        model_reset();
        #2;
        @(negedge rclk);
        rrst_n = 1;
    endtask

    typedef struct {
        logic       inc;
        logic       clr;
        logic [4:0] wq;
        int         e_addr;
        int         e_ptr;
        int         e_empty;
        int         e_uf;
        int         e_lvl;
        int         e_ae;
    } vec_t;

    vec_t vt[12];
    logic [AW:0] prev_ptr;
    int wcnt;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 5'b00000, 0, 5'b00000, 1, 0, 0, 1};
        vt[1]  = '{1'b0, 1'b0, 5'b00001, 0, 5'b00000, 0, 0, 1, 1};
        vt[2]  = '{1'b1, 1'b0, 5'b00001, 1, 5'b00001, 1, 0, 0, 1};
        vt[3]  = '{1'b1, 1'b0, 5'b00001, 1, 5'b00001, 1, 1, 0, 1};
        vt[4]  = '{1'b1, 1'b0, 5'b00001, 1, 5'b00001, 1, 1, 0, 1};
        vt[5]  = '{1'b1, 1'b1, 5'b00001, 1, 5'b00001, 1, 1, 0, 1};
        vt[6]  = '{1'b0, 1'b1, 5'b00001, 1, 5'b00001, 1, 0, 0, 1};
        vt[7]  = '{1'b0, 1'b0, 5'b00010, 1, 5'b00001, 0, 0, 2, 0};
        vt[8]  = '{1'b1, 1'b0, 5'b00010, 2, 5'b00011, 0, 0, 1, 1};
        vt[9]  = '{1'b1, 1'b0, 5'b00010, 3, 5'b00010, 1, 0, 0, 1};
        vt[10] = '{1'b1, 1'b0, 5'b00110, 3, 5'b00010, 0, 1, 1, 1};
        vt[11] = '{1'b0, 1'b1, 5'b00110, 3, 5'b00010, 0, 0, 1, 1};

        // Asynchronous reset before any clock edge
        do_reset();
        tick();
        model_cmp("post_reset");

        for (int i = 0; i < 12; i++) begin
            rinc = vt[i].inc; runderflow_clr = vt[i].clr; rq2_wptr = vt[i].wq;
            tick();
            chk($sformatf("vec%0d_raddr", i), int'(raddr), vt[i].e_addr);
            chk($sformatf("vec%0d_rptr", i), int'(rptr), vt[i].e_ptr);
            chk($sformatf("vec%0d_rempty", i), int'(rempty), vt[i].e_empty);
            chk($sformatf("vec%0d_runderflow", i), int'(runderflow), vt[i].e_uf);
            chk($sformatf("vec%0d_rd_level", i), int'(rd_level), LVL_EN ? vt[i].e_lvl : 0);
            chk($sformatf("vec%0d_ralmost_empty", i), int'(ralmost_empty), LVL_EN ? vt[i].e_ae : 1);
        end

        // Mid-cycle asynchronous reset: clock is high, no edge until checked
        rinc = 1; rq2_wptr = 5'b00110;
        @(posedge rclk); #2;
        rrst_n = 0; rq2_wptr = '0;
        #1;
        chk("async_rst_rempty", int'(rempty), 1);
        chk("async_rst_rptr", int'(rptr), 0);
        chk("async_rst_raddr", int'(raddr), 0);
        chk("async_rst_runderflow", int'(runderflow), 0);
        chk("async_rst_rd_level", int'(rd_level), 0);
        chk("async_rst_ralmost_empty", int'(ralmost_empty), 1);
        do_reset();

        // Wrap: writer kept 8 entries ahead, 32 pops
        rq2_wptr = 5'(gray(8));
        tick();
        chk("wrap_pre_rempty", int'(rempty), 0);
        prev_ptr = rptr;
        for (int k = 0; k < 32; k++) begin
            rinc = 1; rq2_wptr = 5'(gray((k + 8) % PW));
            tick();
            chk($sformatf("wrap%0d_raddr", k), int'(raddr), (k + 1) % 16);
            chk($sformatf("wrap%0d_ham", k), $countones(rptr ^ prev_ptr), 1);
            prev_ptr = rptr;
        end
        chk("wrap_rptr_final", int'(rptr), 0);
        rinc = 0;
        do_reset();

        // Level: 16 entries visible, then drain
        rq2_wptr = 5'b11000;
        tick();
        chk("lvl_full_level", int'(rd_level), LVL_EN ? 16 : 0);
        chk("lvl_full_ae", int'(ralmost_empty), LVL_EN ? 0 : 1);
        chk("lvl_full_rempty", int'(rempty), 0);
        rinc = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("lvl_pop%0d_level", k), int'(rd_level), LVL_EN ? 16 - k : 0);
            chk($sformatf("lvl_pop%0d_ae", k), int'(ralmost_empty), (LVL_EN && (16 - k) > 1) ? 0 : 1);
        end
        chk("lvl_drained_rempty", int'(rempty), 1);
        rinc = 0;
        do_reset();

        // Randomized traffic, writer never more than 16 entries ahead
        wcnt = 0;
        for (int c = 0; c < 600; c++) begin
            if ((((wcnt - m_r) + PW) % PW) < 16 && ($urandom % 2 == 1))
                wcnt = (wcnt + 1) % PW;
            rq2_wptr = 5'(gray(wcnt));
            rinc = ($urandom % 3 != 0);
            runderflow_clr = ($urandom % 8 == 0);
            tick();
            model_cmp("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and flag controller of the async FIFO, in the rclk domain. Consumes the write pointer after it has been synchronised into rclk (rq2_wptr, Gray code) and maintains the read pointer in binary and Gray form. It drives the RAM read address and the empty flag, and publishes the Gray read pointer for the r2w synchroniser. It is the read end of the pointer-crossing scheme whose write end feeds the w2r synchroniser.

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
AE_THRESH, 1, almost-empty threshold in entries; only used with RD_LEVEL_EN.

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  asynchronous active-low reset
rinc  input  1  read request; pops one entry when rempty=0
runderflow_clr  input  1  clears the sticky underflow flag
rq2_wptr  input  ADDRSIZE+1  write pointer (Gray), already 2-flop synchronised to rclk
raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0]
rptr  output  ADDRSIZE+1  registered Gray read pointer, goes to the r2w synchroniser
rempty  output  1  registered empty flag
runderflow  output  1  sticky flag: rinc seen while rempty=1
rd_level  output  ADDRSIZE+1  registered fill level (RD_LEVEL_EN only)
ralmost_empty  output  1  registered almost-empty flag (RD_LEVEL_EN only)

Behaviour:
- Reset (rrst_n=0, asynchronous, all flops): rbin=0, rptr=0, raddr=0, rempty=1, runderflow=0, rd_level=0, ralmost_empty=1.
- The read is valid when rinc & ~rempty.
- Next binary pointer: rbinnext = rbin + valid read, computed modulo 2^(ADDRSIZE+1).
- Next Gray pointer: rgraynext = (rbinnext>>1) ^ rbinnext.
- On each rclk edge: rbin<=rbinnext, rptr<=rgraynext, rempty<=(rgraynext==rq2_wptr).
- rptr is a flop output. It changes by exactly one bit per pop and no combinational path reaches it.
- rempty latency: rempty updates on the same edge as the pop that empties the FIFO. No extra bubble.
- A write becomes visible as rempty=0 one rclk edge after rq2_wptr changes, i.e. about 3 rclk after the write-side pointer update.
- rinc while rempty=1: pointer unchanged and no RAM side effect. runderflow<=1 on that edge.
- runderflow is cleared only by reset or by runderflow_clr=1. If set and clear occur in the same cycle, set wins.
- Wrap-around: rbin 2^(ADDRSIZE+1)-1 -> 0. The Gray pointer wraps with a single-bit change. raddr wraps every 2^ADDRSIZE pops.
- rq2_wptr changing on the same edge as a pop: the compare uses the current rq2_wptr and the new rgraynext. rempty is therefore never deasserted falsely. It may be pessimistically 1 for one extra cycle, which is acceptable.
- Full is not detected here. The block trusts the write side never to exceed depth.
- Reset mid-operation: all state returns to reset values immediately, regardless of rinc.

Optional Feature:
Macro RD_LEVEL_EN.
- Defined:
  - wbin = Gray-to-binary of rq2_wptr (XOR prefix from MSB).
  - rd_level <= (wbin - rbinnext) mod 2^(ADDRSIZE+1). Legal range is 0..2^ADDRSIZE.
  - ralmost_empty <= (that level <= AE_THRESH). It updates on the same edge as rempty.
- Not defined:
  - rd_level is tied to 0 and ralmost_empty to 1.
  - No Gray-to-binary logic or subtractor is synthesised.
  - The ports remain present.

Test Plan:
- Reset: assert rrst_n=0 mid-clock with rq2_wptr=0 -> rempty=1, rptr=5'b00000, raddr=0, runderflow=0 asynchronously, without waiting for rclk.
- Single entry: rq2_wptr=5'b00001 -> rempty=0 after the next edge. Pulse rinc 1 cycle -> raddr=1, rptr=5'b00001, rempty=1 on that same edge.
- Underflow: rempty=1, rinc=1 for 2 cycles -> rbin stays 0, runderflow=1 and stays 1. runderflow_clr and rinc asserted together -> runderflow remains 1. runderflow_clr alone -> runderflow=0.
- Wrap: model the writer stepping rq2_wptr in Gray ahead of reads. Perform 32 pops (ADDRSIZE=4) -> rptr returns to 5'b00000. Every rptr transition has Hamming distance 1. raddr sequence 0..15,0..15.
- Level (RD_LEVEL_EN, AE_THRESH=1): rq2_wptr=5'b11000 (binary 16), rptr=0 -> rd_level=16, ralmost_empty=0, rempty=0. After 15 pops -> rd_level=1, ralmost_empty=1. After 16 pops -> rd_level=0, rempty=1.
- Level without RD_LEVEL_EN: same stimulus -> rd_level=0 and ralmost_empty=1 in every cycle.
